// File: rtl/user_ycbcr2rgb_multi_if.sv
// Video bus for the YCbCr-to-RGB converter: YCbCr source timing/data in, RGB timing/data out,
// plus the requested and currently applied conversion mode.
interface user_ycbcr2rgb_multi_if #(
  parameter int W = 8
);
  logic [1:0]     mode;
  logic [3*W-1:0] ycbcr_din;
  logic           ycbcr_h_sync;
  logic           ycbcr_v_sync;
  logic           ycbcr_de;
  logic [3*W-1:0] rgb_dout;
  logic           rgb_h_sync;
  logic           rgb_v_sync;
  logic           rgb_de;
  logic [1:0]     mode_active;

  modport master (
    output mode, ycbcr_din, ycbcr_h_sync, ycbcr_v_sync, ycbcr_de,
    input  rgb_dout, rgb_h_sync, rgb_v_sync, rgb_de, mode_active
  );

  modport slave (
    input  mode, ycbcr_din, ycbcr_h_sync, ycbcr_v_sync, ycbcr_de,
    output rgb_dout, rgb_h_sync, rgb_v_sync, rgb_de, mode_active
  );
endinterface

// File: rtl/user_ycbcr2rgb_multi.sv
// Four-stage YCbCr-to-RGB converter (BT.601/BT.709 limited, BT.601 full, bypass), mode switched on v_sync rise.
// Define YCC2RGB_422_IN_EN to accept 4:2:2 input with alternating Cb/Cr chroma on the middle component.
module user_ycbcr2rgb_multi #(
  parameter int         BIT_PER_SYMBLE = 8,
  parameter logic [1:0] DEFAULT_MODE   = 2'd0
) (
  input logic                   clk,
  input logic                   rst_n,
  user_ycbcr2rgb_multi_if.slave bus
);
  localparam int W  = BIT_PER_SYMBLE;
  localparam int PW = W + 14;
  localparam int KW = 12;
  localparam logic signed [PW-1:0] HALF     = PW'(1 << (W - 1));
  localparam logic signed [PW-1:0] YOFF_LIM = PW'(16 << (W - 8));
  localparam logic signed [PW-1:0] ROUND    = PW'(128);
  localparam logic signed [PW-1:0] MAX_PIX  = PW'((1 << W) - 1);

  typedef enum logic [1:0] {
    MODE_601_LIM  = 2'd0,
    MODE_709_LIM  = 2'd1,
    MODE_601_FULL = 2'd2,
    MODE_BYPASS   = 2'd3
  } mode_e;

  typedef struct packed {
    logic signed [KW-1:0] ky;
    logic signed [KW-1:0] krcr;
    logic signed [KW-1:0] kgcb;
    logic signed [KW-1:0] kgcr;
    logic signed [KW-1:0] kbcb;
  } coef_t;

  // Coefficients carry 8 fraction bits; bypass reuses the 601 set since its products are discarded.
  function automatic coef_t coef_of(input mode_e m);
    coef_t c;
    case (m)
      MODE_709_LIM:  c = '{12'sd298, 12'sd459, -12'sd55,  -12'sd136, 12'sd541};
      MODE_601_FULL: c = '{12'sd256, 12'sd359, -12'sd88,  -12'sd183, 12'sd454};
      default:       c = '{12'sd298, 12'sd409, -12'sd100, -12'sd208, 12'sd516};
    endcase
    return c;
  endfunction

  function automatic logic signed [PW-1:0] yoff_of(input mode_e m);
    return (m == MODE_601_FULL) ? '0 : YOFF_LIM;
  endfunction

  function automatic logic signed [PW-1:0] sx(input logic signed [KW-1:0] k);
    return PW'(k);
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] s;
    s = v >>> 8;
    if (s[PW-1])         return '0;
    else if (s > MAX_PIX) return '1;
    else                  return s[W-1:0];
  endfunction

  // ---------------------------------------------------------------- input chroma
  logic [W-1:0]   y_in, cb_in, cr_in;
  logic [3*W-1:0] raw_in;

  assign y_in = bus.ycbcr_din[3*W-1:2*W];

`ifdef YCC2RGB_422_IN_EN
  localparam logic [W-1:0] HALF_U = W'(1 << (W - 1));

  logic         phase_odd, pair_seen;
  logic [W-1:0] cb_hold, cr_hold, c_in;

  assign c_in   = bus.ycbcr_din[2*W-1:W];
  assign raw_in = {bus.ycbcr_din[3*W-1:W], {W{1'b0}}};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    cb_in = c_in;
    cr_in = pair_seen ? cr_hold : HALF_U;
    if (phase_odd) begin
      cb_in = cb_hold;
      cr_in = c_in;
    end
  end

  // Phase restarts on every de-low gap so each line begins on a Cb sample with neutral Cr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_odd <= 1'b0;
      pair_seen <= 1'b0;
      cb_hold   <= '0;
      cr_hold   <= '0;
    end else if (!bus.ycbcr_de) begin
      phase_odd <= 1'b0;
      pair_seen <= 1'b0;
    end else if (!phase_odd) begin
      cb_hold   <= c_in;
      phase_odd <= 1'b1;
    end else begin
      cr_hold   <= c_in;
      phase_odd <= 1'b0;
      pair_seen <= 1'b1;
    end
  end
`else
  assign cr_in  = bus.ycbcr_din[2*W-1:W];
  assign cb_in  = bus.ycbcr_din[W-1:0];
  assign raw_in = bus.ycbcr_din;
`endif

  // ---------------------------------------------------------------- mode latch
  logic  vs_d, vs_armed, vs_rise;
  mode_e mode_act;

  // vs_armed blocks a v_sync held high through reset release from looking like a rising edge.
  assign vs_rise         = vs_armed & ~vs_d & bus.ycbcr_v_sync;
  assign bus.mode_active = mode_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      vs_armed <= 1'b0;
      mode_act <= mode_e'(DEFAULT_MODE);
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      vs_d     <= bus.ycbcr_v_sync;
      vs_armed <= 1'b1;
      if (vs_rise) mode_act <= mode_e'(bus.mode);
    end
  end

  // ---------------------------------------------------------------- pipeline
  logic signed [PW-1:0] dy_c, dcb_c, dcr_c;
  coef_t                k1;

  assign dy_c  = $signed(PW'(y_in)) - yoff_of(mode_act);
  assign dcb_c = $signed(PW'(cb_in)) - HALF;
  assign dcr_c = $signed(PW'(cr_in)) - HALF;

  mode_e                s1_mode, s2_mode, s3_mode;
  logic [2:0]           s1_tim, s2_tim, s3_tim;
  logic [3*W-1:0]       s1_raw, s2_raw, s3_raw;
  logic signed [PW-1:0] s1_dy, s1_dcb, s1_dcr;
  logic signed [PW-1:0] s2_py, s2_prc, s2_pgb, s2_pgr, s2_pbb;
  logic signed [PW-1:0] s3_r, s3_g, s3_b;

  assign k1 = coef_of(s1_mode);

  // Each pixel carries the mode it entered with, so a switch never alters pixels already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= MODE_601_LIM;  s2_mode <= MODE_601_LIM;  s3_mode <= MODE_601_LIM;
      s1_tim  <= '0;  s2_tim <= '0;  s3_tim <= '0;
      s1_raw  <= '0;  s2_raw <= '0;  s3_raw <= '0;
      s1_dy   <= '0;  s1_dcb <= '0;  s1_dcr <= '0;
      s2_py   <= '0;  s2_prc <= '0;  s2_pgb <= '0;  s2_pgr <= '0;  s2_pbb <= '0;
      s3_r    <= '0;  s3_g   <= '0;  s3_b   <= '0;
      bus.rgb_dout   <= '0;
      bus.rgb_h_sync <= 1'b0;
      bus.rgb_v_sync <= 1'b0;
      bus.rgb_de     <= 1'b0;
    end else begin
      s1_mode <= mode_act;
      s1_tim  <= {bus.ycbcr_h_sync, bus.ycbcr_v_sync, bus.ycbcr_de};
      s1_raw  <= raw_in;
      s1_dy   <= dy_c;
      s1_dcb  <= dcb_c;
      s1_dcr  <= dcr_c;

      s2_mode <= s1_mode;
      s2_tim  <= s1_tim;
      s2_raw  <= s1_raw;
      s2_py   <= s1_dy  * sx(k1.ky);
      s2_prc  <= s1_dcr * sx(k1.krcr);
      s2_pgb  <= s1_dcb * sx(k1.kgcb);
      s2_pgr  <= s1_dcr * sx(k1.kgcr);
      s2_pbb  <= s1_dcb * sx(k1.kbcb);

      s3_mode <= s2_mode;
      s3_tim  <= s2_tim;
      s3_raw  <= s2_raw;
      s3_r    <= s2_py + s2_prc + ROUND;
      s3_g    <= s2_py + s2_pgb + s2_pgr + ROUND;
      s3_b    <= s2_py + s2_pbb + ROUND;

      if (s3_mode == MODE_BYPASS) bus.rgb_dout <= s3_raw;
      else                        bus.rgb_dout <= {sat(s3_r), sat(s3_g), sat(s3_b)};
      {bus.rgb_h_sync, bus.rgb_v_sync, bus.rgb_de} <= s3_tim;
    end
  end

endmodule

// File: tb/tb_user_ycbcr2rgb_multi.sv
// Directed, table-driven bench for user_ycbcr2rgb_multi at W=8 with hand-computed RGB values.
module tb_user_ycbcr2rgb_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  user_ycbcr2rgb_multi_if #(.W(8)) bus ();

  user_ycbcr2rgb_multi #(.BIT_PER_SYMBLE(8), .DEFAULT_MODE(2'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [23:0] rgb;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    bus.mode = m;
    bus.ycbcr_v_sync = 1'b0;
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b1;
    @(posedge clk);
    #1 check("mode_latch", bus.mode_active, m);
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b0;
  endtask

  // One pixel with de high for a single cycle; output must appear on the 4th edge, not the 3rd.
  task automatic run_pixel(input logic [23:0] din, input logic [23:0] exp, input string name);
    @(negedge clk);
    bus.ycbcr_din = din;
    bus.ycbcr_de  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ycbcr_de  = 1'b0;
    bus.ycbcr_din = '0;
    repeat (2) @(posedge clk);
    #1 check({name, "_early_de"}, bus.rgb_de, 1'b0);
    @(posedge clk);
    #1 check({name, "_de"}, bus.rgb_de, 1'b1);
    check(name, bus.rgb_dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    vec_t        vecs [10];
    logic [1:0]  cur;
    logic [7:0]  chroma [4];
    logic [23:0] exp422 [4];

    vecs[0] = '{2'd0, 8'd16,  8'd128, 8'd128, 24'h000000, "m0_black"};
    vecs[1] = '{2'd0, 8'd235, 8'd128, 8'd128, 24'hFFFFFF, "m0_white"};
    vecs[2] = '{2'd0, 8'd16,  8'd0,   8'd128, 24'h003200, "m0_b_clamp_low"};
    vecs[3] = '{2'd0, 8'd255, 8'd0,   8'd255, 24'hFFE114, "m0_r_clamp_high"};
    vecs[4] = '{2'd0, 8'd128, 8'd128, 8'd200, 24'hF54882, "m0_cr200"};
    vecs[5] = '{2'd1, 8'd128, 8'd128, 8'd200, 24'hFF5C82, "m1_cr200"};
    vecs[6] = '{2'd1, 8'd100, 8'd200, 8'd60,  24'h0076FA, "m1_mixed"};
    vecs[7] = '{2'd2, 8'd255, 8'd128, 8'd128, 24'hFFFFFF, "m2_white"};
    vecs[8] = '{2'd2, 8'd100, 8'd50,  8'd200, 24'hC94B00, "m2_mixed"};
    vecs[9] = '{2'd3, 8'd18,  8'd86,  8'd52,  24'h123456, "m3_bypass"};

    chroma = '{8'd90, 8'd200, 8'd90, 8'd200};
    exp422 = '{24'h829136, 24'hF55736, 24'hF55736, 24'hF55736};

    bus.mode = 2'd0;
    bus.ycbcr_din = '0;
    bus.ycbcr_h_sync = 1'b0;
    bus.ycbcr_v_sync = 1'b0;
    bus.ycbcr_de = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", bus.rgb_dout, 24'h0);
    check("reset_de", bus.rgb_de, 1'b0);
    check("reset_hs", bus.rgb_h_sync, 1'b0);
    check("reset_mode", bus.mode_active, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // h_sync passes through with the same 4-cycle delay
    @(negedge clk);
    bus.ycbcr_h_sync = 1'b1;
    @(negedge clk);
    bus.ycbcr_h_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("hs_early", bus.rgb_h_sync, 1'b0);
    @(posedge clk);
    #1 check("hs_delay4", bus.rgb_h_sync, 1'b1);
    @(posedge clk);
    #1 check("hs_fall", bus.rgb_h_sync, 1'b0);

`ifndef YCC2RGB_422_IN_EN
    cur = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].mode != cur) begin
        set_mode(vecs[i].mode);
        cur = vecs[i].mode;
      end
      run_pixel({vecs[i].y, vecs[i].cr, vecs[i].cb}, vecs[i].rgb, vecs[i].name);
    end

    // Mode request 2->3 mid-frame takes effect only at the next v_sync rise
    set_mode(2'd2);
    @(negedge clk);
    bus.mode = 2'd3;
    run_pixel(24'hFF8080, 24'hFFFFFF, "m2_after_req3");
    check("mode_held", bus.mode_active, 2'd2);
    @(negedge clk);
    bus.ycbcr_din = 24'hFF8080;
    bus.ycbcr_de = 1'b1;
    bus.ycbcr_v_sync = 1'b1;
    @(posedge clk);
    #1 check("mode_switch", bus.mode_active, 2'd3);
    @(negedge clk);
    bus.ycbcr_din = 24'h123456;
    @(posedge clk);
    @(negedge clk);
    bus.ycbcr_de = 1'b0;
    bus.ycbcr_v_sync = 1'b0;
    bus.ycbcr_din = '0;
    @(posedge clk);
    @(posedge clk);
    #1 check("inflight_old_mode", bus.rgb_dout, 24'hFFFFFF);
    check("inflight_vs", bus.rgb_v_sync, 1'b1);
    @(posedge clk);
    #1 check("switch_bypass", bus.rgb_dout, 24'h123456);
`else
    // 4:2:2 line: first even pixel has neutral Cr, later pairs use held chroma
    cur = 2'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        bus.ycbcr_din = {8'd128, chroma[k], 8'd0};
        bus.ycbcr_de = 1'b1;
      end else begin
        bus.ycbcr_din = '0;
        bus.ycbcr_de = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k >= 3) check($sformatf("yc422_px%0d", k - 3), bus.rgb_dout, exp422[k-3]);
    end
    run_pixel({8'd128, chroma[0], 8'd0}, exp422[0], "yc422_line_restart");
    check("yc422_mode", bus.mode_active, cur);
`endif

    // Asynchronous reset mid-line with v_sync held high across release
    set_mode(2'd3);
    @(negedge clk);
    bus.ycbcr_din = 24'hEB8080;
    bus.ycbcr_de = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("pre_reset_de", bus.rgb_de, 1'b1);
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout", bus.rgb_dout, 24'h0);
    check("rst_de", bus.rgb_de, 1'b0);
    check("rst_vs", bus.rgb_v_sync, 1'b0);
    check("rst_mode", bus.mode_active, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check($sformatf("restart_no_de%0d", k), bus.rgb_de, 1'b0);
    end
    @(posedge clk);
    #1 check("restart_de", bus.rgb_de, 1'b1);
    check("restart_dout", bus.rgb_dout, 24'hFFFFFF);
    check("no_spurious_vs", bus.mode_active, 2'd0);
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b0;
    bus.ycbcr_de = 1'b0;
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b1;
    @(posedge clk);
    #1 check("vs_after_reset", bus.mode_active, 2'd3);
    @(negedge clk);
    bus.ycbcr_v_sync = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
